// File: rtl/lsu_mem_ctrl.sv
// Load/store initiator for the word-only data RAM: sub-word lane extraction, extension and read-modify-write.
// Optional misalignment checking is enabled with LSU_ALIGN_CHECK_EN; otherwise sub-word addresses are aligned down.
module lsu_mem_ctrl #(
    parameter int unsigned MEM_SIZE  = 512,
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned IDX_WIDTH = 9
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_we,
    input  logic [1:0]             req_size,
    input  logic                   req_signed,
    input  logic [IDX_WIDTH+1:0]   req_addr,
    input  logic [WIDTH-1:0]       req_wdata,
    output logic                   rsp_valid,
    output logic [WIDTH-1:0]       rsp_rdata,
    output logic                   rsp_err,
    output logic [IDX_WIDTH-1:0]   mem_addr,
    output logic [WIDTH-1:0]       mem_wdata,
    output logic                   mem_we,
    input  logic [WIDTH-1:0]       mem_rdata
);
    typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, MERGE = 2'd2, RESP = 2'd3} state_e;

    if (WIDTH != 32) begin : g_bad_width
        $error("lsu_mem_ctrl: only WIDTH=32 is supported");
    end
    if (MEM_SIZE > (1 << IDX_WIDTH)) begin : g_bad_depth
        $error("lsu_mem_ctrl: MEM_SIZE exceeds the word-index range");
    end

    state_e                state_q, state_d;
    logic                  we_q, we_d;
    logic [1:0]            size_q, size_d;
    logic                  sgn_q, sgn_d;
    logic [1:0]            off_q, off_d;
    logic [15:0]           wdata_q, wdata_d;
    logic                  req_ready_q, req_ready_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0]      rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q, rsp_err_d;
    logic [IDX_WIDTH-1:0]  mem_addr_q, mem_addr_d;
    logic [WIDTH-1:0]      mem_wdata_q, mem_wdata_d;
    logic                  mem_we_q, mem_we_d;

    logic                  xfer_c;
    logic                  misalign_c;
    logic [IDX_WIDTH+1:0]  addr_eff_c;
    logic [7:0]            byte_c;
    logic [15:0]           half_c;
    logic [WIDTH-1:0]      load_c;
    logic [WIDTH-1:0]      merge_c;

    assign xfer_c = req_valid && req_ready_q;

    // Alignment policy for the incoming request
    always_comb begin
        addr_eff_c = req_addr;
        misalign_c = 1'b0;
`ifdef LSU_ALIGN_CHECK_EN
        misalign_c = ((req_size == 2'b01) && req_addr[0]) ||
                     (req_size[1] && (req_addr[1:0] != 2'b00));
`else
        if (req_size == 2'b01) begin
            addr_eff_c[0] = 1'b0;
        end else if (req_size[1]) begin
            addr_eff_c[1:0] = 2'b00;
        end
`endif
    end

    // Lane extraction for loads and lane replacement for sub-word stores
    always_comb begin
        byte_c  = mem_rdata[{off_q, 3'b000} +: 8];
        half_c  = mem_rdata[{off_q[1], 4'b0000} +: 16];
        merge_c = mem_rdata;
        case (size_q)
            2'b00:   begin
                load_c = {{(WIDTH-8){sgn_q & byte_c[7]}}, byte_c};
                merge_c[{off_q, 3'b000} +: 8] = wdata_q[7:0];
            end
            2'b01:   begin
                load_c = {{(WIDTH-16){sgn_q & half_c[15]}}, half_c};
                merge_c[{off_q[1], 4'b0000} +: 16] = wdata_q;
            end
            default: load_c = mem_rdata;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (xfer_c) state_d = misalign_c ? RESP : ACCESS;
            ACCESS:  state_d = (we_q && !size_q[1]) ? MERGE : RESP;
            MERGE:   state_d = RESP;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        we_d        = we_q;
        size_d      = size_q;
        sgn_d       = sgn_q;
        off_d       = off_q;
        wdata_d     = wdata_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = 1'b0;
        req_ready_d = (state_d == IDLE);
        rsp_valid_d = (state_d == RESP);
        case (state_q)
            IDLE: begin
                if (xfer_c) begin
                    we_d       = req_we;
                    size_d     = req_size;
                    sgn_d      = req_signed;
                    off_d      = addr_eff_c[1:0];
                    wdata_d    = req_wdata[15:0];
                    mem_addr_d = addr_eff_c[IDX_WIDTH+1:2];
                    if (misalign_c) begin
                        rsp_rdata_d = '0;
                        rsp_err_d   = 1'b1;
                    end else if (req_we && req_size[1]) begin
                        mem_we_d    = 1'b1;
                        mem_wdata_d = req_wdata;
                    end
                end
            end
            ACCESS: begin
                rsp_err_d = 1'b0;
                if (!we_q) begin
                    rsp_rdata_d = load_c;
                end else if (size_q[1]) begin
                    rsp_rdata_d = '0;
                end else begin
                    mem_we_d    = 1'b1;
                    mem_wdata_d = merge_c;
                end
            end
            MERGE: begin
                rsp_rdata_d = '0;
                rsp_err_d   = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            we_q        <= 1'b0;
            size_q      <= 2'b00;
            sgn_q       <= 1'b0;
            off_q       <= 2'b00;
            wdata_q     <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
        end else begin
            we_q        <= we_d;
            size_q      <= size_d;
            sgn_q       <= sgn_d;
            off_q       <= off_d;
            wdata_q     <= wdata_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_we    = mem_we_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Bench for lsu_mem_ctrl: vector table driven through a response scoreboard, plus reset corner sequences.
module tb_lsu_mem_ctrl;
    logic        clk = 1'b0;
    logic        rst_i;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [10:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [8:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic [31:0] mem_rdata;

    lsu_mem_ctrl dut (
        .clk_i(clk), .rst_i(rst_i),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_we(mem_we), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Word RAM: async read, sync write, plus a backdoor preload port
    logic [31:0] ram [512];
    logic        pre_we = 1'b0;
    logic [8:0]  pre_idx = 9'd0;
    logic [31:0] pre_val = 32'd0;
    assign mem_rdata = ram[mem_addr];
    always @(posedge clk) begin
        if (pre_we) ram[pre_idx] <= pre_val;
        else if (mem_we) ram[mem_addr] <= mem_wdata;
    end

    typedef struct {
        logic        we;
        logic [1:0]  sz;
        logic        sg;
        logic [10:0] addr;
        logic [31:0] wd;
        logic [31:0] rd;
        logic        err;
        int          lat;
        int          wen;
        logic [31:0] mwd;
        bit          hold;
    } vec_t;

    typedef struct {
        int          id;
        logic [31:0] rd;
        logic        err;
        int          lat;
        int          wen;
        logic [31:0] mwd;
        logic [8:0]  idx;
        int          t;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_vec = 0;
    int   n_mis = 0;
    int   we_seen = 0;
    int   last_rsp = 0;
    bit   prev_hold = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        n_vec++;
        n_mis++;
        $display("FAIL %s: got event expected none", nm);
    endtask

    function automatic vec_t mk(input logic we, input logic [1:0] sz, input logic sg,
                                input logic [10:0] a, input logic [31:0] wd, input logic [31:0] rd,
                                input logic er, input int lat, input int wen,
                                input logic [31:0] mwd, input bit hold);
        vec_t v;
        v.we = we; v.sz = sz; v.sg = sg; v.addr = a; v.wd = wd; v.rd = rd;
        v.err = er; v.lat = lat; v.wen = wen; v.mwd = mwd; v.hold = hold;
        return v;
    endfunction

    // Scoreboard monitor: RAM writes and responses against the outstanding expectation
    always @(negedge clk) begin
        if (mem_we) begin
            if (sb.size() == 0) begin
                fail_now("unexpected_mem_we");
            end else begin
                we_seen++;
                chk($sformatf("v%0d mem_wdata", sb[0].id), mem_wdata, sb[0].mwd);
                chk($sformatf("v%0d mem_addr", sb[0].id), 32'(mem_addr), 32'(sb[0].idx));
            end
        end
        if (rsp_valid) begin
            chk("ready_low_in_resp", 32'(req_ready), 32'd0);
            if (sb.size() == 0) begin
                fail_now("unexpected_rsp_valid");
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk($sformatf("v%0d rdata", e.id), rsp_rdata, e.rd);
                chk($sformatf("v%0d err", e.id), 32'(rsp_err), 32'(e.err));
                chk($sformatf("v%0d latency", e.id), 32'(cyc - e.t + 1), 32'(e.lat));
                chk($sformatf("v%0d we_cycles", e.id), 32'(we_seen), 32'(e.wen));
                last_rsp = cyc;
            end
            we_seen = 0;
        end
    end

    task automatic push_exp(input int id, input vec_t v);
        exp_t e;
        e.id = id; e.rd = v.rd; e.err = v.err; e.lat = v.lat; e.wen = v.wen;
        e.mwd = v.mwd; e.idx = v.addr[10:2]; e.t = cyc;
        sb.push_back(e);
    endtask

    task automatic do_req(input int id, input vec_t v, input bit expect_rsp);
        int w;
        @(negedge clk);
        req_valid = 1'b1; req_we = v.we; req_size = v.sz; req_signed = v.sg;
        req_addr = v.addr; req_wdata = v.wd;
        w = 0;
        while (!req_ready && w < 40) begin
            @(negedge clk);
            w++;
        end
        if (!req_ready) begin
            fail_now($sformatf("v%0d ready_timeout", id));
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        if (prev_hold) chk($sformatf("v%0d b2b_gap_ok", id), 32'((cyc - last_rsp) >= 2), 32'd1);
        prev_hold = v.hold;
        if (expect_rsp) push_exp(id, v);
        if (!v.hold) req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int w;
        w = 0;
        while (sb.size() != 0 && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (sb.size() != 0) begin
            fail_now("rsp_timeout");
            sb.delete();
        end
        @(negedge clk);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " req_ready"}, 32'(req_ready), 32'd1);
        chk({tag, " rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, " rsp_rdata"}, rsp_rdata, 32'd0);
        chk({tag, " rsp_err"}, 32'(rsp_err), 32'd0);
        chk({tag, " mem_we"}, 32'(mem_we), 32'd0);
        chk({tag, " mem_addr"}, 32'(mem_addr), 32'd0);
        chk({tag, " mem_wdata"}, mem_wdata, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got hang expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vt[20];
        vec_t v;
        logic [31:0] idx3_final;

        vt[0]  = mk(0, 2'b00, 1, 11'h00D, 32'h0, 32'hFFFFFFAA, 0, 2, 0, 32'h0, 0);
        vt[1]  = mk(0, 2'b00, 0, 11'h00D, 32'h0, 32'h000000AA, 0, 2, 0, 32'h0, 0);
        vt[2]  = mk(0, 2'b01, 1, 11'h00E, 32'h0, 32'hFFFF8899, 0, 2, 0, 32'h0, 0);
        vt[3]  = mk(0, 2'b01, 0, 11'h00E, 32'h0, 32'h00008899, 0, 2, 0, 32'h0, 0);
        vt[4]  = mk(0, 2'b10, 0, 11'h00C, 32'h0, 32'h8899AABB, 0, 2, 0, 32'h0, 0);
        vt[5]  = mk(0, 2'b00, 1, 11'h00C, 32'h0, 32'hFFFFFFBB, 0, 2, 0, 32'h0, 0);
        vt[6]  = mk(0, 2'b00, 0, 11'h00F, 32'h0, 32'h00000088, 0, 2, 0, 32'h0, 0);
        vt[7]  = mk(1, 2'b00, 0, 11'h00E, 32'h1234565A, 32'h0, 0, 3, 1, 32'h885AAABB, 0);
        vt[8]  = mk(0, 2'b10, 0, 11'h00C, 32'h0, 32'h885AAABB, 0, 2, 0, 32'h0, 0);
        vt[9]  = mk(1, 2'b10, 0, 11'h010, 32'hDEADBEEF, 32'h0, 0, 2, 1, 32'hDEADBEEF, 1);
        vt[10] = mk(0, 2'b10, 0, 11'h010, 32'h0, 32'hDEADBEEF, 0, 2, 0, 32'h0, 0);
        vt[11] = mk(1, 2'b01, 0, 11'h012, 32'hFFFF1234, 32'h0, 0, 3, 1, 32'h1234BEEF, 0);
        vt[12] = mk(0, 2'b01, 1, 11'h012, 32'h0, 32'h00001234, 0, 2, 0, 32'h0, 0);
        vt[13] = mk(0, 2'b00, 1, 11'h011, 32'h0, 32'hFFFFFFBE, 0, 2, 0, 32'h0, 0);
        vt[14] = mk(0, 2'b11, 1, 11'h010, 32'h0, 32'h1234BEEF, 0, 2, 0, 32'h0, 0);
        vt[15] = mk(1, 2'b00, 0, 11'h010, 32'h000000C3, 32'h0, 0, 3, 1, 32'h1234BEC3, 0);
        vt[16] = mk(0, 2'b00, 1, 11'h010, 32'h0, 32'hFFFFFFC3, 0, 2, 0, 32'h0, 0);
`ifdef LSU_ALIGN_CHECK_EN
        vt[17] = mk(1, 2'b10, 0, 11'h00D, 32'hCAFEF00D, 32'h0, 1, 1, 0, 32'h0, 0);
        vt[18] = mk(0, 2'b10, 0, 11'h00C, 32'h0, 32'h885AAABB, 0, 2, 0, 32'h0, 0);
        vt[19] = mk(0, 2'b01, 0, 11'h00F, 32'h0, 32'h0, 1, 1, 0, 32'h0, 0);
        idx3_final = 32'h885AAABB;
`else
        vt[17] = mk(1, 2'b10, 0, 11'h00D, 32'hCAFEF00D, 32'h0, 0, 2, 1, 32'hCAFEF00D, 0);
        vt[18] = mk(0, 2'b10, 0, 11'h00C, 32'h0, 32'hCAFEF00D, 0, 2, 0, 32'h0, 0);
        vt[19] = mk(0, 2'b01, 0, 11'h00F, 32'h0, 32'h0000CAFE, 0, 2, 0, 32'h0, 0);
        idx3_final = 32'hCAFEF00D;
`endif

        rst_i = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
        req_signed = 1'b0; req_addr = '0; req_wdata = '0;
        @(negedge clk);
        pre_we = 1'b1; pre_idx = 9'd3; pre_val = 32'h8899AABB;
        @(negedge clk);
        pre_idx = 9'd4; pre_val = 32'h0;
        @(negedge clk);
        pre_we = 1'b0;
        chk_reset_outputs("reset");
        rst_i = 1'b0;

        for (int i = 0; i < 20; i++) begin
            do_req(i, vt[i], 1'b1);
            if (!vt[i].hold) wait_idle();
        end
        chk("ram idx3", ram[3], idx3_final);
        chk("ram idx4", ram[4], 32'h1234BEC3);

        // Sub-word store aborted by reset during ACCESS: no write, no response
        v = mk(1, 2'b01, 0, 11'h00C, 32'h00007777, 32'h0, 0, 0, 0, 32'h0, 0);
        do_req(100, v, 1'b0);
        @(negedge clk);
        rst_i = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;
        chk_reset_outputs("abort");
        repeat (4) @(negedge clk);
        chk("abort ram idx3", ram[3], idx3_final);

        // Request held valid across reset is accepted on the first edge after release
        @(negedge clk);
        rst_i = 1'b1;
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_signed = 1'b0;
        req_addr = 11'h010; req_wdata = 32'h0;
        @(negedge clk);
        @(negedge clk);
        rst_i = 1'b0;
        chk("held ready_after_reset", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        v = mk(0, 2'b10, 0, 11'h010, 32'h0, 32'h1234BEC3, 0, 2, 0, 32'h0, 0);
        push_exp(101, v);
        req_valid = 1'b0;
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end
endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
- Load/store initiator between the Mini-MIPS execute stage and the word-only data RAM (async read, sync write, word-indexed, no byte enables).
- Accepts byte/halfword/word loads and stores on a valid/ready request channel and drives the RAM's word interface.
- Performs lane extraction and sign/zero extension for loads, and read-modify-write for sub-word stores.
- Returns a single-cycle response pulse.

Parameters:
MEM_SIZE, 512, RAM depth in 32-bit words
WIDTH, 32, data width; only 32 supported
IDX_WIDTH, 9, word-index width; byte address is IDX_WIDTH+2 bits

Ports:
clk_i  in  1  clock, all state on rising edge
rst_i  in  1  synchronous active-high reset
req_valid  in  1  request present
req_ready  out  1  controller can accept request
req_we  in  1  1=store, 0=load
req_size  in  2  00=byte, 01=half, 10=word, 11=reserved (treated as word)
req_signed  in  1  load sign-extends when 1
req_addr  in  IDX_WIDTH+2  byte address
req_wdata  in  WIDTH  store data, right-aligned
rsp_valid  out  1  one-cycle response pulse
rsp_rdata  out  WIDTH  load result (0 for stores)
rsp_err  out  1  misaligned access, qualified by rsp_valid
mem_addr  out  IDX_WIDTH  word index to RAM
mem_wdata  out  WIDTH  word written to RAM
mem_we  out  1  RAM write enable
mem_rdata  in  WIDTH  RAM async read data for mem_addr

Behaviour:
- Reset values: state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, mem_we=0, mem_addr=0, mem_wdata=0. All request latches cleared.
- Handshake: transfer on rising edge with req_valid&&req_ready. req_ready=1 only in IDLE; one outstanding request. Inputs are sampled only at the transfer edge and may change afterward.
- FSM: IDLE, ACCESS, MERGE, RESP.
- IDLE -> ACCESS on transfer. The request is latched and mem_addr=req_addr[IDX_WIDTH+1:2] is registered.
- IDLE -> RESP directly on transfer if misaligned: half with addr[0]=1, or word with addr[1:0]!=0. Sets rsp_err=1 and never asserts mem_we.
- ACCESS, load: at the edge, capture mem_rdata, select the lane by addr[1:0] (little-endian; byte k = bits 8k+7:8k; half at addr[1]), extend per req_signed, store into rsp_rdata -> RESP.
- ACCESS, word store: mem_we=1 and mem_wdata=wdata during the ACCESS cycle; the write commits at the edge -> RESP.
- ACCESS, byte/half store: mem_we=0. Capture mem_rdata as the old word -> MERGE.
- MERGE: mem_we=1 and mem_wdata = old word with the addressed lane replaced by wdata[7:0] or wdata[15:0]. Commits at the edge -> RESP.
- RESP: rsp_valid=1 for exactly this cycle -> IDLE. rsp_rdata and rsp_err hold until the next response.
- Latency from transfer edge T to rsp_valid high:
  - misaligned: cycle after T
  - load / word store: cycle after T+1
  - sub-word store: cycle after T+2
- Throughput: next transfer edge is at the earliest the RESP edge +1 (req_ready is low in RESP).
- mem_we, mem_addr, mem_wdata are functions of registered state and latched request only; no combinational path from req_* to mem_*.
- Upper bits of req_wdata are ignored for sub-word stores.
- Reset mid-operation:
  - returns to IDLE at the reset edge and drops mem_we from the next cycle
  - an RMW reset during ACCESS leaves memory unmodified
  - reset coincident with the MERGE edge: write still commits, since the RAM samples mem_we=1 on that edge
  - no response is issued for an aborted request
- req_valid held high across reset: accepted on the first edge after reset deasserts.

Optional Feature:
- Macro LSU_ALIGN_CHECK_EN.
- Defined: misalignment detection as above; rsp_err can be 1.
- Undefined: no check. Halfword addresses force addr[0]=0 and word addresses force addr[1:0]=0 (aligned down); the access proceeds normally; rsp_err tied 0.
- Ports are identical in both builds.

Test Plan:
1. Preload word idx 3 = 0x8899AABB; load byte signed addr 0x00D -> rsp_rdata=0xFFFFFFAA at T+2. Unsigned -> 0x000000AA.
2. Load half signed addr 0x00E -> 0xFFFF8899. Load word addr 0x00C -> 0x8899AABB, rsp_err=0.
3. Store byte wdata=0x1234565A addr 0x00E -> exactly one mem_we cycle (MERGE) with mem_wdata=0x885AAABB. rsp_valid at T+3. RAM idx 3 reads 0x885AAABB.
4. Store word 0xDEADBEEF addr 0x010 -> mem_we in ACCESS only, idx 4=0xDEADBEEF, rsp_valid at T+2. req_valid held continuously -> next transfer no earlier than the cycle after rsp_valid.
5. LSU_ALIGN_CHECK_EN defined: store word addr 0x00D -> rsp_valid at T+1, rsp_err=1, mem_we never high, idx 3 unchanged. Undefined: same request writes idx 3, rsp_err=0.
6. Store half to 0x00C, assert rst_i during ACCESS -> no mem_we, no rsp_valid, idx 3 unchanged, req_ready=1 the cycle after reset deasserts, all outputs at reset values.
